// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch + data) in front of a single-port memory, one access at a time.
// Optional MEM_ARB_RR_EN: ties in IDLE alternate via a last-grant flop; otherwise data always wins.
module mem_arbiter #(
  parameter int unsigned LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] if_data,
  output logic [15:0] dm_data,
  output logic        if_done,
  output logic        dm_done,
  output logic        if_stall,
  output logic        dm_stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  localparam logic [3:0] LAST_CNT = 4'(LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q, wdata_q;
  logic        wr_q;
  logic [15:0] if_data_q, dm_data_q;
  logic        if_done_q, dm_done_q;

  logic dm_req, idle_ok, grant_dm, grant_if, busy, access_end;

  assign dm_req = dm_rd ^ dm_wr;
  assign err    = dm_rd & dm_wr;
  // A done pulse blocks arbitration for that cycle, so a requester that is
  // still asserting in its done cycle is issued no earlier than done + 2.
  assign idle_ok    = (state_q == IDLE) && !if_done_q && !dm_done_q;
  assign busy       = (state_q != IDLE);
  assign access_end = busy && (cnt_q == LAST_CNT);

`ifdef MEM_ARB_RR_EN
  logic last_dm_q;
  assign grant_dm = idle_ok && dm_req && (!if_req || !last_dm_q);
`else
  assign grant_dm = idle_ok && dm_req;
`endif
  assign grant_if = idle_ok && if_req && !grant_dm;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_dm)      state_d = DM_BUSY;
        else if (grant_if) state_d = IF_BUSY;
      end
      IF_BUSY, DM_BUSY: if (access_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (busy) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_rd    = (cnt_q == 4'd0) && ((state_q == IF_BUSY) || !wr_q);
      mem_wr    = (cnt_q == 4'd0) && (state_q == DM_BUSY) && wr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      if_data_q <= '0;
      dm_data_q <= '0;
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
    end else begin
      if_done_q <= access_end && (state_q == IF_BUSY);
      dm_done_q <= access_end && (state_q == DM_BUSY);
      if (grant_dm) begin
        cnt_q   <= '0;
        addr_q  <= dm_addr;
        wdata_q <= dm_wdata;
        wr_q    <= dm_wr;
      end else if (grant_if) begin
        cnt_q   <= '0;
        addr_q  <= if_addr;
        wdata_q <= '0;
        wr_q    <= 1'b0;
      end else if (busy) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if (access_end && (state_q == IF_BUSY))          if_data_q <= mem_rdata;
      if (access_end && (state_q == DM_BUSY) && !wr_q) dm_data_q <= mem_rdata;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Reset to "fetch granted last" so the data side wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst)          last_dm_q <= 1'b0;
    else if (grant_dm) last_dm_q <= 1'b1;
    else if (grant_if) last_dm_q <= 1'b0;
  end
`endif

  assign if_data  = if_data_q;
  assign dm_data  = dm_data_q;
  assign if_done  = if_done_q;
  assign dm_done  = dm_done_q;
  assign if_stall = if_req & ~if_done_q;
  assign dm_stall = (dm_rd | dm_wr) & ~dm_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at LAT=4: vector table for single accesses and the
// illegal request, plus hand sequences for contention and reset during an access.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        dm_rd, dm_wr;
  logic [15:0] dm_addr, dm_wdata, mem_rdata;
  logic [15:0] mem_addr, mem_wdata, if_data, dm_data;
  logic        mem_rd, mem_wr, if_done, dm_done, if_stall, dm_stall, err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LAT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .if_data(if_data), .dm_data(dm_data), .if_done(if_done), .dm_done(dm_done),
    .if_stall(if_stall), .dm_stall(dm_stall), .err(err)
  );

  typedef struct packed {
    logic        rst, if_req;
    logic [15:0] if_addr;
    logic        dm_rd, dm_wr;
    logic [15:0] dm_addr, dm_wdata, mem_rdata;
    logic        e_mem_rd, e_mem_wr;
    logic [15:0] e_mem_addr, e_mem_wdata;
    logic        e_if_done, e_dm_done;
    logic [15:0] e_if_data, e_dm_data;
    logic        e_if_stall, e_dm_stall, e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0d got=%h exp=%h", name, idx, act, exp);
    end
  endtask

  // Inputs are driven just after the rising edge, outputs sampled at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    rst = v.rst; if_req = v.if_req; if_addr = v.if_addr;
    dm_rd = v.dm_rd; dm_wr = v.dm_wr; dm_addr = v.dm_addr;
    dm_wdata = v.dm_wdata; mem_rdata = v.mem_rdata;
    @(negedge clk);
    check("mem_rd",    idx, 16'(mem_rd),   16'(v.e_mem_rd));
    check("mem_wr",    idx, 16'(mem_wr),   16'(v.e_mem_wr));
    check("mem_addr",  idx, mem_addr,      v.e_mem_addr);
    check("mem_wdata", idx, mem_wdata,     v.e_mem_wdata);
    check("if_done",   idx, 16'(if_done),  16'(v.e_if_done));
    check("dm_done",   idx, 16'(dm_done),  16'(v.e_dm_done));
    check("if_data",   idx, if_data,       v.e_if_data);
    check("dm_data",   idx, dm_data,       v.e_dm_data);
    check("if_stall",  idx, 16'(if_stall), 16'(v.e_if_stall));
    check("dm_stall",  idx, 16'(dm_stall), 16'(v.e_dm_stall));
    check("err",       idx, 16'(err),      16'(v.e_err));
    next_cycle();
  endtask

  task automatic drive_idle();
    if_req = 1'b0; if_addr = '0; dm_rd = 1'b0; dm_wr = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
  endtask

  int          issue_cyc [3];
  logic [15:0] issue_adr [3];
  int          n_issue, n_if_done, n_dm_done;
  logic [15:0] exp_adr1;
  int          exp_if_done, exp_dm_done;

  initial begin
    vec_t v;
    rst = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    v = '0;
    vecs.push_back(v);
    // Fetch read: issue cycle 1, done/data cycle 5, stall cycles 0-4
    for (int c = 0; c <= 6; c++) begin
      v = '0;
      v.rst        = 1'b1;
      v.if_req     = (c <= 5);
      v.if_addr    = 16'h0010;
      v.mem_rdata  = (c == 4 || c == 5) ? 16'hA5A5 : 16'hDEAD;
      v.e_mem_rd   = (c == 1);
      v.e_mem_addr = (c >= 1 && c <= 4) ? 16'h0010 : 16'h0000;
      v.e_if_done  = (c == 5);
      v.e_if_data  = (c >= 5) ? 16'hA5A5 : 16'h0000;
      v.e_if_stall = (c <= 4);
      vecs.push_back(v);
    end
    // Data write: one mem_wr pulse, dm_done cycle 5, dm_data untouched
    for (int c = 0; c <= 6; c++) begin
      v = '0;
      v.rst         = 1'b1;
      v.dm_wr       = (c <= 5);
      v.dm_addr     = 16'h0200;
      v.dm_wdata    = 16'h1234;
      v.mem_rdata   = 16'hBEEF;
      v.e_mem_wr    = (c == 1);
      v.e_mem_addr  = (c >= 1 && c <= 4) ? 16'h0200 : 16'h0000;
      v.e_mem_wdata = (c >= 1 && c <= 4) ? 16'h1234 : 16'h0000;
      v.e_dm_done   = (c == 5);
      v.e_if_data   = 16'hA5A5;
      v.e_dm_stall  = (c <= 4);
      vecs.push_back(v);
    end
    // Illegal read+write: err and dm_stall high, never issued
    for (int c = 0; c <= 6; c++) begin
      v = '0;
      v.rst        = 1'b1;
      v.dm_rd      = (c <= 5);
      v.dm_wr      = (c <= 5);
      v.dm_addr    = 16'h0300;
      v.dm_wdata   = 16'h5555;
      v.mem_rdata  = 16'h1111;
      v.e_if_data  = 16'hA5A5;
      v.e_dm_stall = (c <= 5);
      v.e_err      = (c <= 5);
      vecs.push_back(v);
    end

    foreach (vecs[i]) apply(vecs[i], i);

    // Contention: both requesters held; fresh reset so the last-grant flag is "fetch"
    rst = 1'b0;
    drive_idle();
    next_cycle();
    rst = 1'b1;
    if_req = 1'b1; if_addr = 16'h0040;
    dm_rd = 1'b1;  dm_addr = 16'h0300;
    mem_rdata = 16'h7777;
    n_issue = 0; n_if_done = 0; n_dm_done = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (mem_rd) begin
        if (n_issue < 3) begin
          issue_cyc[n_issue] = c;
          issue_adr[n_issue] = mem_addr;
        end
        n_issue++;
      end
      if (if_done) n_if_done++;
      if (dm_done) n_dm_done++;
      next_cycle();
    end
    drive_idle();
`ifdef MEM_ARB_RR_EN
    exp_adr1 = 16'h0040; exp_if_done = 1; exp_dm_done = 2;
`else
    exp_adr1 = 16'h0300; exp_if_done = 0; exp_dm_done = 3;
`endif
    check("cont_issues", 0, 16'(n_issue), 16'd3);
    if (n_issue >= 3) begin
      check("cont_cyc0", 0, 16'(issue_cyc[0]), 16'd1);
      check("cont_cyc1", 1, 16'(issue_cyc[1]), 16'd7);
      check("cont_cyc2", 2, 16'(issue_cyc[2]), 16'd13);
      check("cont_adr0", 0, issue_adr[0], 16'h0300);
      check("cont_adr1", 1, issue_adr[1], exp_adr1);
      check("cont_adr2", 2, issue_adr[2], 16'h0300);
    end
    check("cont_if_done", 0, 16'(n_if_done), 16'(exp_if_done));
    check("cont_dm_done", 0, 16'(n_dm_done), 16'(exp_dm_done));
    next_cycle();

    // Reset in cycle 3 of a fetch: abandoned, re-issued the cycle after rst returns high
    if_req = 1'b1; if_addr = 16'h0080; mem_rdata = 16'h4242;
    @(negedge clk);                                   // cycle 0
    next_cycle();
    @(negedge clk);                                   // cycle 1
    check("rst_issue", 1, 16'(mem_rd), 16'd1);
    next_cycle();
    next_cycle();                                     // cycle 3: rst low
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;                                       // cycle 4
    @(negedge clk);
    check("rst_mem_rd",  4, 16'(mem_rd), 16'd0);
    check("rst_addr",    4, mem_addr, 16'h0000);
    check("rst_if_data", 4, if_data, 16'h0000);
    check("rst_dm_data", 4, dm_data, 16'h0000);
    check("rst_if_done", 4, 16'(if_done), 16'd0);
    next_cycle();
    @(negedge clk);                                   // cycle 5
    check("reissue_rd",   5, 16'(mem_rd), 16'd1);
    check("reissue_addr", 5, mem_addr, 16'h0080);
    check("no_old_done",  5, 16'(if_done), 16'd0);
    for (int c = 6; c <= 9; c++) begin
      next_cycle();
      @(negedge clk);
      check("reissue_done", c, 16'(if_done), (c == 9) ? 16'd1 : 16'd0);
    end
    check("reissue_data", 9, if_data, 16'h4242);
    next_cycle();
    drive_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
